mem_excp_collect: RTL and testbench

- MEM-stage exception collector that sits directly upstream of the CP0 block.
- Registers the retiring MEM-stage instruction and checks load/store alignment.
- Merges the alignment result with exception flags carried down the pipe, then emits a one-hot exception vector, PC, bad address and delay-slot flag for CP0 to sample.
- After any exception or ERET, squashes younger instructions until CP0 flush returns. Holds the last committed PC so interrupts taken on bubbles get a correct EPC.

---
 rtl/mem_excp_collect_pkg.sv | 55 +++++
 rtl/mem_excp_collect_if.sv | 44 ++++
 rtl/mem_excp_collect_excp_prio_enc.sv | 30 +++
 rtl/mem_excp_collect.sv | 126 ++++++++++++
 tb/tb_mem_excp_collect.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_excp_collect_pkg.sv
// Shared definitions for the MEM-stage exception collector: CP0 exception
// bit positions, memory access size encodings, upstream flag field indices,
// the FSM state type and the raw-flag bundle fed to the priority encoder.
package mem_excp_collect_pkg;

  // Bit positions in the one-hot vector handed to CP0
  localparam int EXCP_BIT_ADEL_F = 31;
  localparam int EXCP_BIT_RI     = 30;
  localparam int EXCP_BIT_OV     = 29;
  localparam int EXCP_BIT_BP     = 28;
  localparam int EXCP_BIT_SYS    = 27;
  localparam int EXCP_BIT_ADEL_D = 26;
  localparam int EXCP_BIT_ADES   = 25;
  localparam int EXCP_BIT_ERET   = 0;

  // Data access size encodings (3 behaves as a word)
  localparam logic [1:0] MEM_SZ_B = 2'd0;
  localparam logic [1:0] MEM_SZ_H = 2'd1;
  localparam logic [1:0] MEM_SZ_W = 2'd2;

  // Field indices of excp_flags_i
  localparam int FLAG_ADEL_F = 5;
  localparam int FLAG_RI     = 4;
  localparam int FLAG_OV     = 3;
  localparam int FLAG_BP     = 2;
  localparam int FLAG_SYS    = 1;
  localparam int FLAG_ERET   = 0;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_SQUASH = 1'b1
  } state_t;

  // Raw exception causes, declared highest priority first
  typedef struct packed {
    logic adel_f;
    logic ri;
    logic ov;
    logic bp;
    logic sys;
    logic adel_d;
    logic ades;
    logic eret;
  } raw_excp_t;

  // Alignment check for a data access of the given size
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      MEM_SZ_B: misaligned = 1'b0;
      MEM_SZ_H: misaligned = addr_lo[0];
      default:  misaligned = |addr_lo;
    endcase
  endfunction

endpackage

// File: rtl/mem_excp_collect_if.sv
// Bus between the MEM stage / CP0 and the exception collector.
// Optional: MEM_EXCP_STAT_EN adds the excp_count_o statistics output.
interface mem_excp_collect_if;
  logic        valid_i;
  logic [31:0] pc_i;
  logic        in_delayslot_i;
  logic [5:0]  excp_flags_i;
  logic        mem_re_i;
  logic        mem_we_i;
  logic [1:0]  mem_size_i;
  logic [31:0] mem_addr_i;
  logic        flush_i;
  logic [31:0] exception_type_o;
  logic [31:0] pc_o;
  logic [31:0] exception_addr_o;
  logic        now_in_delayslot_o;
  logic        mem_kill_o;
  logic        busy_o;
`ifdef MEM_EXCP_STAT_EN
  logic [15:0] excp_count_o;
`endif

  // Collector side
  modport slave (
    input  valid_i, pc_i, in_delayslot_i, excp_flags_i, mem_re_i, mem_we_i,
           mem_size_i, mem_addr_i, flush_i,
    output exception_type_o, pc_o, exception_addr_o, now_in_delayslot_o,
           mem_kill_o, busy_o
`ifdef MEM_EXCP_STAT_EN
    , output excp_count_o
`endif
  );

  // Pipeline / CP0 side
  modport master (
    output valid_i, pc_i, in_delayslot_i, excp_flags_i, mem_re_i, mem_we_i,
           mem_size_i, mem_addr_i, flush_i,
    input  exception_type_o, pc_o, exception_addr_o, now_in_delayslot_o,
           mem_kill_o, busy_o
`ifdef MEM_EXCP_STAT_EN
    , input excp_count_o
`endif
  );
endinterface

// File: rtl/mem_excp_collect_excp_prio_enc.sv
// Fixed-priority encoder: picks the highest-priority raw exception cause and
// emits it as a one-hot CP0 vector; addr_sel marks a data-address fault win.
module excp_prio_enc
  import mem_excp_collect_pkg::*;
(
  input  raw_excp_t   raw,
  output logic [31:0] vec,
  output logic        addr_sel
);

  // Priority chain, fetch AdEL first, ERET last
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    vec      = '0;
    addr_sel = 1'b0;
    if (raw.adel_f)      vec[EXCP_BIT_ADEL_F] = 1'b1;
    else if (raw.ri)     vec[EXCP_BIT_RI]     = 1'b1;
    else if (raw.ov)     vec[EXCP_BIT_OV]     = 1'b1;
    else if (raw.bp)     vec[EXCP_BIT_BP]     = 1'b1;
    else if (raw.sys)    vec[EXCP_BIT_SYS]    = 1'b1;
    else if (raw.adel_d) begin
      vec[EXCP_BIT_ADEL_D] = 1'b1;
      addr_sel             = 1'b1;
    end else if (raw.ades) begin
      vec[EXCP_BIT_ADES] = 1'b1;
      addr_sel           = 1'b1;
    end else if (raw.eret) vec[EXCP_BIT_ERET] = 1'b1;
  end

endmodule

// File: rtl/mem_excp_collect.sv
// MEM-stage exception collector feeding CP0. Registers the retiring
// instruction, checks data alignment, prioritises causes, and squashes
// younger instructions after an exception/ERET until CP0 flushes or a
// timeout expires. Optional: MEM_EXCP_STAT_EN adds a saturating count of
// taken exceptions (ERET excluded) on excp_count_o.
module mem_excp_collect
  import mem_excp_collect_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'hbfc0_0000,
  parameter int unsigned FLUSH_WAIT = 3
) (
  input  logic               clock_i,
  input  logic               reset_i,
  mem_excp_collect_if.slave  bus
);

  localparam logic [3:0] WAIT_INIT = 4'(FLUSH_WAIT);

  state_t      state, state_nxt;
  logic [3:0]  sq_cnt;
  raw_excp_t   raw;
  logic [31:0] vec;
  logic        addr_sel;
  logic        mis;
  logic        accept;
  logic        excp_any;
  logic [31:0] type_q;
  logic [31:0] pc_q;
  logic [31:0] addr_q;
  logic        ds_q;
  logic        busy;
  logic        kill;

  assign mis      = misaligned(bus.mem_size_i, bus.mem_addr_i[1:0]);
  assign accept   = bus.valid_i & (state == ST_RUN) & ~bus.flush_i;
  assign excp_any = |vec;

  // Gather raw causes; a load+store combination is treated as a load
  always_comb begin
    raw        = '0;
    raw.adel_f = bus.excp_flags_i[FLAG_ADEL_F];
    raw.ri     = bus.excp_flags_i[FLAG_RI];
    raw.ov     = bus.excp_flags_i[FLAG_OV];
    raw.bp     = bus.excp_flags_i[FLAG_BP];
    raw.sys    = bus.excp_flags_i[FLAG_SYS];
    raw.adel_d = bus.mem_re_i & mis;
    raw.ades   = bus.mem_we_i & mis & ~bus.mem_re_i;
    raw.eret   = bus.excp_flags_i[FLAG_ERET];
  end

  excp_prio_enc u_prio (
    .raw      (raw),
    .vec      (vec),
    .addr_sel (addr_sel)
  );

  // FSM state register
  always_ff @(posedge clock_i or posedge reset_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset_i) state <= ST_RUN;
    else         state <= state_nxt;
  end

  // FSM next state: enter SQUASH on any taken exception, leave on flush or timeout
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:    if (accept && excp_any) state_nxt = ST_SQUASH;
      ST_SQUASH: if (bus.flush_i || sq_cnt == 4'd1) state_nxt = ST_RUN;
      default:   state_nxt = ST_RUN;
    endcase
  end

  // FSM outputs: busy flag and combinational data-request kill
  always_comb begin
    busy = (state == ST_SQUASH);
    kill = busy | bus.flush_i |
           (bus.valid_i & ((|bus.excp_flags_i[5:1]) |
                           ((bus.mem_re_i | bus.mem_we_i) & mis)));
  end

  // Squash timeout counter
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i)                        sq_cnt <= '0;
    else if (accept && excp_any)        sq_cnt <= WAIT_INIT;
    else if (state == ST_SQUASH)        sq_cnt <= sq_cnt - 4'd1;
  end

  // CP0-facing registers: load on accept, bubbles clear the vector only
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      type_q <= '0;
      pc_q   <= RESET_PC;
      addr_q <= '0;
      ds_q   <= 1'b0;
    end else if (accept) begin
      type_q <= vec;
      pc_q   <= bus.pc_i;
      ds_q   <= bus.in_delayslot_i;
      if (addr_sel) addr_q <= bus.mem_addr_i;
    end else begin
      type_q <= '0;
    end
  end

  assign bus.exception_type_o   = type_q;
  assign bus.pc_o               = pc_q;
  assign bus.exception_addr_o   = addr_q;
  assign bus.now_in_delayslot_o = ds_q;
  assign bus.busy_o             = busy;
  assign bus.mem_kill_o         = kill;

`ifdef MEM_EXCP_STAT_EN
  logic [15:0] stat_count;

  // Saturating count of taken exceptions, ERET excluded
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) stat_count <= '0;
    else if (accept && excp_any && !vec[EXCP_BIT_ERET] && stat_count != 16'hffff)
      stat_count <= stat_count + 16'd1;
  end

  assign bus.excp_count_o = stat_count;
`endif

endmodule

// File: tb/tb_mem_excp_collect.sv
// Self-checking bench for mem_excp_collect: directed vector table, hand
// sequences for reset/saturation corners, and randomized stimulus against
// a behavioural model.
module tb_mem_excp_collect;

  localparam logic [31:0] RESET_PC   = 32'hbfc0_0000;
  localparam int          FLUSH_WAIT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_excp_collect_if bus ();

  mem_excp_collect #(.RESET_PC(RESET_PC), .FLUSH_WAIT(FLUSH_WAIT)) dut (
    .clock_i (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h expected=%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic        ds;
    logic [5:0]  flags;
    logic        re;
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic        flush;
    logic        e_kill;
    logic [31:0] e_type;
    logic [31:0] e_pc;
    logic [31:0] e_addr;
    logic        e_ds;
    logic        e_busy;
  } vec_t;

  // ---------------- behavioural model ----------------
  bit          m_squash;
  int          m_left;
  logic [31:0] m_type, m_pc, m_addr;
  logic        m_ds;
  int          m_count;

  function automatic bit ref_mis(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd0)      return 1'b0;
    else if (sz == 2'd1) return (a % 2) != 0;
    else                 return (a % 4) != 0;
  endfunction

  function automatic bit model_kill();
    bit m = ref_mis(bus.mem_size_i, bus.mem_addr_i);
    return m_squash || bus.flush_i ||
           (bus.valid_i && ((bus.excp_flags_i[5:1] != 0) ||
                            ((bus.mem_re_i || bus.mem_we_i) && m)));
  endfunction

  task automatic model_reset();
    m_squash = 0; m_left = 0; m_type = 0; m_pc = RESET_PC; m_addr = 0; m_ds = 0; m_count = 0;
  endtask

  task automatic model_step();
    int  bitpos[8] = '{31, 30, 29, 28, 27, 26, 25, 0};
    bit  cause[8];
    bit  m;
    int  win;
    if (bus.valid_i && !m_squash && !bus.flush_i) begin
      m = ref_mis(bus.mem_size_i, bus.mem_addr_i);
      cause[0] = bus.excp_flags_i[5];
      cause[1] = bus.excp_flags_i[4];
      cause[2] = bus.excp_flags_i[3];
      cause[3] = bus.excp_flags_i[2];
      cause[4] = bus.excp_flags_i[1];
      cause[5] = bus.mem_re_i && m;
      cause[6] = bus.mem_we_i && m && !bus.mem_re_i;
      cause[7] = bus.excp_flags_i[0];
      win = -1;
      for (int k = 7; k >= 0; k--) if (cause[k]) win = k;
      m_pc = bus.pc_i;
      m_ds = bus.in_delayslot_i;
      if (win < 0) m_type = 0;
      else begin
        m_type = 32'h1 << bitpos[win];
        if (win == 5 || win == 6) m_addr = bus.mem_addr_i;
        m_squash = 1;
        m_left   = FLUSH_WAIT;
        if (win != 7 && m_count < 65535) m_count++;
      end
    end else begin
      m_type = 0;
      if (m_squash) begin
        if (bus.flush_i || m_left == 1) m_squash = 0;
        m_left--;
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic set_inputs(input logic v, input logic [31:0] pc, input logic ds,
                            input logic [5:0] fl, input logic re, input logic we,
                            input logic [1:0] sz, input logic [31:0] a, input logic f);
    bus.valid_i = v; bus.pc_i = pc; bus.in_delayslot_i = ds; bus.excp_flags_i = fl;
    bus.mem_re_i = re; bus.mem_we_i = we; bus.mem_size_i = sz; bus.mem_addr_i = a;
    bus.flush_i = f;
  endtask

  task automatic idle();
    set_inputs(0, 32'h0, 0, 6'h0, 0, 0, 2'd0, 32'h0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle();
    #1;
    model_reset();
    check("reset_type", bus.exception_type_o, 32'h0);
    check("reset_pc", bus.pc_o, RESET_PC);
    check("reset_addr", bus.exception_addr_o, 32'h0);
    check("reset_ds", {31'h0, bus.now_in_delayslot_o}, 32'h0);
    check("reset_busy", {31'h0, bus.busy_o}, 32'h0);
`ifdef MEM_EXCP_STAT_EN
    check("reset_count", {16'h0, bus.excp_count_o}, 32'h0);
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic step_one(input string tag, input logic [5:0] fl, input logic f);
    set_inputs(1, 32'h100, 0, fl, 0, 0, 2'd2, 32'h0, f);
    @(posedge clk);
    @(negedge clk);
    idle();
    bus.flush_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    idle();
    check({tag, "_busy"}, {31'h0, bus.busy_o}, 32'h0);
  endtask

  vec_t tbl[18];

  initial begin
    // valid  pc            ds flags      re we sz    addr          fl kill type           pc             addr           ds busy
    tbl[0]  = '{1, 32'hbfc00100, 0, 6'b000000, 1, 0, 2'd2, 32'h10000002, 0, 1, 32'h04000000, 32'hbfc00100, 32'h10000002, 0, 1};
    tbl[1]  = '{0, 32'h0,        0, 6'b000000, 0, 0, 2'd0, 32'h0,        1, 1, 32'h0,        32'hbfc00100, 32'h10000002, 0, 0};
    tbl[2]  = '{1, 32'hbfc00104, 1, 6'b000000, 0, 1, 2'd1, 32'h00000001, 0, 1, 32'h02000000, 32'hbfc00104, 32'h00000001, 1, 1};
    tbl[3]  = '{0, 32'h0,        0, 6'b000000, 0, 0, 2'd0, 32'h0,        0, 1, 32'h0,        32'hbfc00104, 32'h00000001, 1, 1};
    tbl[4]  = '{0, 32'h0,        0, 6'b000000, 0, 0, 2'd0, 32'h0,        1, 1, 32'h0,        32'hbfc00104, 32'h00000001, 1, 0};
    tbl[5]  = '{1, 32'hbfc00108, 0, 6'b010010, 1, 0, 2'd2, 32'h20000003, 0, 1, 32'h40000000, 32'hbfc00108, 32'h00000001, 0, 1};
    tbl[6]  = '{0, 32'h0,        0, 6'b000000, 0, 0, 2'd0, 32'h0,        1, 1, 32'h0,        32'hbfc00108, 32'h00000001, 0, 0};
    tbl[7]  = '{1, 32'hbfc0010c, 0, 6'b000001, 0, 0, 2'd0, 32'h0,        0, 0, 32'h00000001, 32'hbfc0010c, 32'h00000001, 0, 1};
    tbl[8]  = '{0, 32'h0,        0, 6'b000000, 0, 0, 2'd0, 32'h0,        0, 1, 32'h0,        32'hbfc0010c, 32'h00000001, 0, 1};
    tbl[9]  = '{0, 32'h0,        0, 6'b000000, 0, 0, 2'd0, 32'h0,        0, 1, 32'h0,        32'hbfc0010c, 32'h00000001, 0, 1};
    tbl[10] = '{0, 32'h0,        0, 6'b000000, 0, 0, 2'd0, 32'h0,        0, 1, 32'h0,        32'hbfc0010c, 32'h00000001, 0, 0};
    tbl[11] = '{1, 32'h00000080, 0, 6'b000000, 0, 0, 2'd2, 32'h0,        0, 0, 32'h0,        32'h00000080, 32'h00000001, 0, 0};
    tbl[12] = '{0, 32'h0,        0, 6'b000000, 0, 0, 2'd0, 32'h0,        0, 0, 32'h0,        32'h00000080, 32'h00000001, 0, 0};
    tbl[13] = '{0, 32'h0,        0, 6'b000000, 0, 0, 2'd0, 32'h0,        0, 0, 32'h0,        32'h00000080, 32'h00000001, 0, 0};
    tbl[14] = '{1, 32'h00000090, 0, 6'b000000, 0, 1, 2'd1, 32'h00000002, 0, 0, 32'h0,        32'h00000090, 32'h00000001, 0, 0};
    tbl[15] = '{1, 32'h00000094, 0, 6'b000000, 1, 0, 2'd0, 32'h00000003, 0, 0, 32'h0,        32'h00000094, 32'h00000001, 0, 0};
    tbl[16] = '{1, 32'h00000098, 0, 6'b001000, 0, 0, 2'd0, 32'h0,        1, 1, 32'h0,        32'h00000094, 32'h00000001, 0, 0};
    tbl[17] = '{1, 32'h00000088, 0, 6'b000000, 1, 1, 2'd2, 32'h00000006, 0, 1, 32'h04000000, 32'h00000088, 32'h00000006, 0, 1};

    idle();
    do_reset();

    // Directed table
    for (int i = 0; i < 18; i++) begin
      set_inputs(tbl[i].valid, tbl[i].pc, tbl[i].ds, tbl[i].flags, tbl[i].re,
                 tbl[i].we, tbl[i].size, tbl[i].addr, tbl[i].flush);
      #1;
      check($sformatf("row%0d_kill", i), {31'h0, bus.mem_kill_o}, {31'h0, tbl[i].e_kill});
      @(posedge clk);
      @(negedge clk);
      check($sformatf("row%0d_type", i), bus.exception_type_o, tbl[i].e_type);
      check($sformatf("row%0d_pc", i), bus.pc_o, tbl[i].e_pc);
      check($sformatf("row%0d_addr", i), bus.exception_addr_o, tbl[i].e_addr);
      check($sformatf("row%0d_ds", i), {31'h0, bus.now_in_delayslot_o}, {31'h0, tbl[i].e_ds});
      check($sformatf("row%0d_busy", i), {31'h0, bus.busy_o}, {31'h0, tbl[i].e_busy});
    end

    // Asynchronous reset while squashing takes effect without a clock edge
    idle();
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_pc", bus.pc_o, RESET_PC);
    check("async_rst_busy", {31'h0, bus.busy_o}, 32'h0);
    check("async_rst_type", bus.exception_type_o, 32'h0);
    check("async_rst_addr", bus.exception_addr_o, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Randomized stimulus against the model
    for (int n = 0; n < 600; n++) begin
      logic [5:0] fl;
      fl = '0;
      for (int b = 0; b < 6; b++) if ($urandom_range(0, 11) == 0) fl[b] = 1'b1;
      set_inputs($urandom_range(0, 3) != 0, $urandom, 1'($urandom_range(0, 1)), fl,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)), $urandom, $urandom_range(0, 7) == 0);
      #1;
      check("rnd_kill", {31'h0, bus.mem_kill_o}, {31'h0, model_kill()});
      @(posedge clk);
      model_step();
      @(negedge clk);
      check("rnd_type", bus.exception_type_o, m_type);
      check("rnd_pc", bus.pc_o, m_pc);
      check("rnd_addr", bus.exception_addr_o, m_addr);
      check("rnd_ds", {31'h0, bus.now_in_delayslot_o}, {31'h0, m_ds});
      check("rnd_busy", {31'h0, bus.busy_o}, {31'h0, m_squash});
`ifdef MEM_EXCP_STAT_EN
      check("rnd_count", {16'h0, bus.excp_count_o}, m_count);
`endif
    end

`ifdef MEM_EXCP_STAT_EN
    // Statistics: three exceptions and one ERET count as three
    do_reset();
    step_one("st_ri", 6'b010000, 0);
    step_one("st_ov", 6'b001000, 0);
    step_one("st_sys", 6'b000010, 0);
    step_one("st_eret", 6'b000001, 0);
    check("stat_count3", {16'h0, bus.excp_count_o}, 32'd3);
    force dut.stat_count = 16'hffff;
    @(posedge clk);
    @(negedge clk);
    release dut.stat_count;
    step_one("st_sat", 6'b010000, 0);
    check("stat_saturate", {16'h0, bus.excp_count_o}, 32'h0000ffff);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
